// File: rtl/calc_sequencer.sv
// calc_sequencer: stage sequencer, operand/opcode capture and arithmetic unit
// for the calculator core. Operands are WIDTH-bit unsigned values. ADD, SUB,
// the bitwise operations and divide-by-zero finish in one CALC cycle. MUL, DIV
// and MOD iterate one bit per cycle and take exactly WIDTH CALC cycles.
//
// Handshake: busy is high on every CALC cycle. done pulses for one cycle on
// the first SHOW cycle, and the new answer/flags become valid in that same
// cycle. There is no ready input, because the result is held until the next
// CALC completes. Button pulses that arrive while busy is high are dropped.
//
// The FSM is one-hot, and `stage` carries the state register directly.
module calc_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 btn_next,
   input  logic                 btn_prev,
   input  logic [WIDTH-1:0]     sw,
   output logic [4:0]           stage,
   output logic [WIDTH-1:0]     num_a,
   output logic [WIDTH-1:0]     num_b,
   output logic [2:0]           opcode,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   answer,
   output logic                 is_negative,
   output logic                 div_zero
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_MOD = 3'b100;
   localparam logic [2:0] OP_AND = 3'b101;
   localparam logic [2:0] OP_OR  = 3'b110;
   localparam logic [2:0] OP_XOR = 3'b111;

   typedef enum logic [4:0] {
      ST_ENTER_A  = 5'b00001,
      ST_ENTER_B  = 5'b00010,
      ST_ENTER_OP = 5'b00100,
      ST_CALC     = 5'b01000,
      ST_SHOW     = 5'b10000
   } state_t;

   state_t state;

   // Iteration state. These registers are never routed to an output.
   logic [CNT_W-1:0]   iter_cnt;
   logic               long_op;
   logic [2*WIDTH-1:0] mul_acc;
   logic [2*WIDTH-1:0] mul_mcand;
   logic [WIDTH-1:0]   mul_mplier;
   logic [WIDTH:0]     div_rem;
   logic [WIDTH-1:0]   div_quo;

   // Combinational helpers.
   logic               next_only;
   logic               prev_only;
   logic               b_zero;
   logic               sw_long;
   logic [2*WIDTH-1:0] quick_answer;
   logic               quick_neg;
   logic               quick_dz;
   logic [2*WIDTH-1:0] mul_acc_step;
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [WIDTH:0]     div_rem_step;
   logic [WIDTH-1:0]   div_quo_step;

   assign stage     = state;
   assign next_only = btn_next & ~btn_prev;
   assign prev_only = btn_prev & ~btn_next;
   assign b_zero    = (num_b == '0);

   // An operation iterates only for MUL, or for DIV/MOD with a non-zero divisor.
   assign sw_long = (sw[2:0] == OP_MUL) ||
                    (((sw[2:0] == OP_DIV) || (sw[2:0] == OP_MOD)) && !b_zero);

   // Single-cycle results. A DIV/MOD that reaches this path has a zero divisor.
   always_comb begin
      quick_answer = '0;
      quick_neg    = 1'b0;
      quick_dz     = 1'b0;
      case (opcode)
         OP_ADD: quick_answer = {{WIDTH{1'b0}}, num_a} + {{WIDTH{1'b0}}, num_b};
         OP_SUB: begin
            if (num_a >= num_b) begin
               quick_answer = {{WIDTH{1'b0}}, num_a - num_b};
            end else begin
               quick_answer = {{WIDTH{1'b0}}, num_b - num_a};
               quick_neg    = 1'b1;
            end
         end
         OP_DIV, OP_MOD: quick_dz = 1'b1;
         OP_AND: quick_answer = {{WIDTH{1'b0}}, num_a & num_b};
         OP_OR:  quick_answer = {{WIDTH{1'b0}}, num_a | num_b};
         OP_XOR: quick_answer = {{WIDTH{1'b0}}, num_a ^ num_b};
         default: quick_answer = '0;
      endcase
   end

   // One shift-add multiply step and one restoring-division step.
   always_comb begin
      mul_acc_step = mul_mplier[0] ? (mul_acc + mul_mcand) : mul_acc;
      div_shift    = {div_rem[WIDTH-1:0], div_quo[WIDTH-1]};
      div_ge       = (div_shift >= {1'b0, num_b});
      div_rem_step = div_ge ? (div_shift - {1'b0, num_b}) : div_shift;
      div_quo_step = {div_quo[WIDTH-2:0], div_ge};
   end

   // Stage FSM, operand capture, iteration and registered result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_ENTER_A;
         num_a       <= '0;
         num_b       <= '0;
         opcode      <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         answer      <= '0;
         is_negative <= 1'b0;
         div_zero    <= 1'b0;
         iter_cnt    <= '0;
         long_op     <= 1'b0;
         mul_acc     <= '0;
         mul_mcand   <= '0;
         mul_mplier  <= '0;
         div_rem     <= '0;
         div_quo     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_ENTER_A: begin
               if (next_only) begin
                  num_a <= sw;
                  state <= ST_ENTER_B;
               end
            end
            ST_ENTER_B: begin
               if (next_only) begin
                  num_b <= sw;
                  state <= ST_ENTER_OP;
               end else if (prev_only) begin
                  state <= ST_ENTER_A;
               end
            end
            ST_ENTER_OP: begin
               if (next_only) begin
                  opcode     <= sw[2:0];
                  state      <= ST_CALC;
                  busy       <= 1'b1;
                  long_op    <= sw_long;
                  iter_cnt   <= '0;
                  mul_acc    <= '0;
                  mul_mcand  <= {{WIDTH{1'b0}}, num_a};
                  mul_mplier <= num_b;
                  div_rem    <= '0;
                  div_quo    <= num_a;
               end else if (prev_only) begin
                  state <= ST_ENTER_B;
               end
            end
            ST_CALC: begin
               if (!long_op) begin
                  answer      <= quick_answer;
                  is_negative <= quick_neg;
                  div_zero    <= quick_dz;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  state       <= ST_SHOW;
               end else begin
                  mul_acc    <= mul_acc_step;
                  mul_mcand  <= {mul_mcand[2*WIDTH-2:0], 1'b0};
                  mul_mplier <= {1'b0, mul_mplier[WIDTH-1:1]};
                  div_rem    <= div_rem_step;
                  div_quo    <= div_quo_step;
                  iter_cnt   <= iter_cnt + CNT_W'(1);
                  if (iter_cnt == LAST_STEP) begin
                     if (opcode == OP_MUL) begin
                        answer <= mul_acc_step;
                     end else if (opcode == OP_DIV) begin
                        answer <= {{WIDTH{1'b0}}, div_quo_step};
                     end else begin
                        answer <= {{WIDTH{1'b0}}, div_rem_step[WIDTH-1:0]};
                     end
                     is_negative <= 1'b0;
                     div_zero    <= 1'b0;
                     busy        <= 1'b0;
                     done        <= 1'b1;
                     state       <= ST_SHOW;
                  end
               end
            end
            ST_SHOW: begin
               if (next_only) begin
                  state <= ST_ENTER_A;
               end else if (prev_only) begin
                  state <= ST_ENTER_OP;
               end
            end
            default: state <= ST_ENTER_A;
         endcase
      end
   end

endmodule
